// File: rtl/pipe_defs.sv
// Shared definitions for the pipeline hazard and redirect controller:
// FSM state encodings, trap kinds and default widths.
package pipe_defs;

   localparam int XLEN_DEF  = 32;
   localparam int CNT_W_DEF = 32;
   localparam int REG_IDX_W = 5;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_REDIR = 2'd2;

   typedef enum logic {
      KIND_TRAP = 1'b0,
      KIND_MRET = 1'b1
   } wb_kind_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stage registers and the hazard/redirect controller.
// The master side is the controller; the slave side is the pipeline.
interface pipe_ctrl_if #(
   parameter int XLEN  = pipe_defs::XLEN_DEF,
   parameter int CNT_W = pipe_defs::CNT_W_DEF
);
   import pipe_defs::*;

   logic                 id_valid_i;
   logic                 id_rs1_ren_i;
   logic [REG_IDX_W-1:0] id_rs1_idx_i;
   logic                 id_rs2_ren_i;
   logic [REG_IDX_W-1:0] id_rs2_idx_i;
   logic                 ex_valid_i;
   logic                 ex_is_load_i;
   logic                 ex_rd_wen_i;
   logic [REG_IDX_W-1:0] ex_rd_idx_i;
   logic                 ex_br_taken_i;
   logic [XLEN-1:0]      ex_br_target_i;
   logic                 wb_valid_i;
   logic                 wb_excp_i;
   logic                 wb_mret_i;
   logic                 mem_busy_i;
   logic [XLEN-1:0]      csr_mtvec_i;
   logic [XLEN-1:0]      csr_mepc_i;

   logic                 if_stall_o;
   logic                 id_stall_o;
   logic                 ex_bubble_o;
   logic                 flush_if_o;
   logic                 flush_id_o;
   logic                 flush_ex_o;
   logic                 flush_mem_o;
   logic                 redirect_o;
   logic [XLEN-1:0]      redirect_pc_o;
   logic                 trap_take_o;
   logic                 mret_take_o;
   logic [1:0]           state_o;
   logic [CNT_W-1:0]     stall_cnt_o;
   logic [CNT_W-1:0]     trap_cnt_o;

   modport master (
      input  id_valid_i, id_rs1_ren_i, id_rs1_idx_i, id_rs2_ren_i, id_rs2_idx_i,
      input  ex_valid_i, ex_is_load_i, ex_rd_wen_i, ex_rd_idx_i,
      input  ex_br_taken_i, ex_br_target_i,
      input  wb_valid_i, wb_excp_i, wb_mret_i, mem_busy_i,
      input  csr_mtvec_i, csr_mepc_i,
      output if_stall_o, id_stall_o, ex_bubble_o,
      output flush_if_o, flush_id_o, flush_ex_o, flush_mem_o,
      output redirect_o, redirect_pc_o, trap_take_o, mret_take_o,
      output state_o, stall_cnt_o, trap_cnt_o
   );

   modport slave (
      output id_valid_i, id_rs1_ren_i, id_rs1_idx_i, id_rs2_ren_i, id_rs2_idx_i,
      output ex_valid_i, ex_is_load_i, ex_rd_wen_i, ex_rd_idx_i,
      output ex_br_taken_i, ex_br_target_i,
      output wb_valid_i, wb_excp_i, wb_mret_i, mem_busy_i,
      output csr_mtvec_i, csr_mepc_i,
      input  if_stall_o, id_stall_o, ex_bubble_o,
      input  flush_if_o, flush_id_o, flush_ex_o, flush_mem_o,
      input  redirect_o, redirect_pc_o, trap_take_o, mret_take_o,
      input  state_o, stall_cnt_o, trap_cnt_o
   );

endinterface

// File: rtl/hazard_det.sv
// Purely combinational load-use detector: a load in EX whose destination
// is read by the instruction in ID. Shared with the forwarding unit.
module hazard_det
   import pipe_defs::*;
(
   input  logic                 id_valid,
   input  logic                 id_rs1_ren,
   input  logic [REG_IDX_W-1:0] id_rs1_idx,
   input  logic                 id_rs2_ren,
   input  logic [REG_IDX_W-1:0] id_rs2_idx,
   input  logic                 ex_valid,
   input  logic                 ex_is_load,
   input  logic                 ex_rd_wen,
   input  logic [REG_IDX_W-1:0] ex_rd_idx,
   output logic                 load_use
);

   logic producer;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired to zero, so a load targeting it never creates a hazard.
   assign producer = ex_valid & ex_is_load & ex_rd_wen & (ex_rd_idx != '0);
   assign rs1_hit  = id_rs1_ren & (id_rs1_idx == ex_rd_idx);
   assign rs2_hit  = id_rs2_ren & (id_rs2_idx == ex_rd_idx);
   assign load_use = producer & id_valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard and redirect scheduler: load-use stalls, branch flushes,
// and a RUN/DRAIN/REDIR sequencer for trap entry and mret.
module pipe_ctrl
   import pipe_defs::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.master bus
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   wb_kind_e         kind;
   wb_kind_e         kind_nxt;
   logic             load_use;
   logic             wb_event;
   logic             stall_take;
   logic             trap_fire;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] trap_cnt;

   logic             if_stall;
   logic             id_stall;
   logic             ex_bubble;
   logic             flush_if;
   logic             flush_id;
   logic             flush_ex;
   logic             flush_mem;
   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;
   logic             trap_take;
   logic             mret_take;

   hazard_det u_hazard_det (
      .id_valid   (bus.id_valid_i),
      .id_rs1_ren (bus.id_rs1_ren_i),
      .id_rs1_idx (bus.id_rs1_idx_i),
      .id_rs2_ren (bus.id_rs2_ren_i),
      .id_rs2_idx (bus.id_rs2_idx_i),
      .ex_valid   (bus.ex_valid_i),
      .ex_is_load (bus.ex_is_load_i),
      .ex_rd_wen  (bus.ex_rd_wen_i),
      .ex_rd_idx  (bus.ex_rd_idx_i),
      .load_use   (load_use)
   );

   assign wb_event = bus.wb_valid_i & (bus.wb_excp_i | bus.wb_mret_i);

   // Priority in RUN is WB event, then taken branch, then load-use.
   // DRAIN and REDIR keep every stage flushed until the redirect has issued.
   always_comb begin
      state_nxt   = state;
      kind_nxt    = kind;
      stall_take  = 1'b0;
      trap_fire   = 1'b0;
      if_stall    = 1'b0;
      id_stall    = 1'b0;
      ex_bubble   = 1'b0;
      flush_if    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      flush_mem   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      trap_take   = 1'b0;
      mret_take   = 1'b0;

      case (state)
         ST_RUN: begin
            if (wb_event) begin
               flush_if  = 1'b1;
               flush_id  = 1'b1;
               flush_ex  = 1'b1;
               flush_mem = 1'b1;
               if_stall  = 1'b1;
               kind_nxt  = bus.wb_excp_i ? KIND_TRAP : KIND_MRET;
               state_nxt = bus.mem_busy_i ? ST_DRAIN : ST_REDIR;
            end else if (bus.ex_br_taken_i) begin
               redirect    = 1'b1;
               redirect_pc = bus.ex_br_target_i;
               flush_if    = 1'b1;
               flush_id    = 1'b1;
            end else if (load_use) begin
               if_stall   = 1'b1;
               id_stall   = 1'b1;
               ex_bubble  = 1'b1;
               stall_take = 1'b1;
            end
         end

         ST_DRAIN: begin
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            if_stall  = 1'b1;
            if (!bus.mem_busy_i) begin
               state_nxt = ST_REDIR;
            end
         end

         ST_REDIR: begin
            flush_if    = 1'b1;
            flush_id    = 1'b1;
            flush_ex    = 1'b1;
            flush_mem   = 1'b1;
            redirect    = 1'b1;
            redirect_pc = (kind == KIND_MRET) ? bus.csr_mepc_i : bus.csr_mtvec_i;
            trap_take   = (kind == KIND_TRAP);
            mret_take   = (kind == KIND_MRET);
            trap_fire   = (kind == KIND_TRAP);
            state_nxt   = ST_RUN;
         end

         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Sequencer state and the latched trap/mret kind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         kind  <= KIND_TRAP;
      end else begin
         state <= state_nxt;
         kind  <= kind_nxt;
      end
   end

   // Stall counter saturates so long runs stay meaningful; trap counter wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         trap_cnt  <= '0;
      end else begin
         if (stall_take && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (trap_fire) begin
            trap_cnt <= trap_cnt + 1'b1;
         end
      end
   end

   assign bus.if_stall_o    = if_stall;
   assign bus.id_stall_o    = id_stall;
   assign bus.ex_bubble_o   = ex_bubble;
   assign bus.flush_if_o    = flush_if;
   assign bus.flush_id_o    = flush_id;
   assign bus.flush_ex_o    = flush_ex;
   assign bus.flush_mem_o   = flush_mem;
   assign bus.redirect_o    = redirect;
   assign bus.redirect_pc_o = redirect_pc;
   assign bus.trap_take_o   = trap_take;
   assign bus.mret_take_o   = mret_take;
   assign bus.state_o       = state;
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.trap_cnt_o    = trap_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_ctrl;

   localparam int XLEN    = 32;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   pipe_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: whether a WB event is being handled, whether the redirect is due
   // this cycle, which kind it is, and the two counters.
   bit m_pending, m_redir, m_mret;
   int m_stall, m_trap;
   bit n_pending, n_redir, n_mret;
   int n_stall, n_trap;

   always @(negedge clk) begin : compare
      bit          e_ifs, e_ids, e_bub, e_fif, e_fid, e_fex, e_fmem, e_red, e_tt, e_mt;
      logic [31:0] e_pc;
      logic [1:0]  e_state;
      bit          lu, ev;
      e_ifs = 0; e_ids = 0; e_bub = 0; e_fif = 0; e_fid = 0; e_fex = 0; e_fmem = 0;
      e_red = 0; e_tt = 0; e_mt = 0; e_pc = '0;
      n_pending = m_pending; n_redir = m_redir; n_mret = m_mret;
      n_stall = m_stall; n_trap = m_trap;
      e_state = m_redir ? 2'd2 : (m_pending ? 2'd1 : 2'd0);
      lu = bus.ex_valid_i && bus.ex_is_load_i && bus.ex_rd_wen_i && (bus.ex_rd_idx_i != 0) &&
           bus.id_valid_i &&
           ((bus.id_rs1_ren_i && (bus.id_rs1_idx_i == bus.ex_rd_idx_i)) ||
            (bus.id_rs2_ren_i && (bus.id_rs2_idx_i == bus.ex_rd_idx_i)));
      ev = bus.wb_valid_i && (bus.wb_excp_i || bus.wb_mret_i);
      if (m_redir) begin
         {e_fif, e_fid, e_fex, e_fmem} = 4'hF;
         e_red = 1;
         e_pc  = m_mret ? bus.csr_mepc_i : bus.csr_mtvec_i;
         e_tt  = !m_mret;
         e_mt  = m_mret;
         n_pending = 0;
         n_redir   = 0;
         if (!m_mret) n_trap = (m_trap + 1) % (CNT_MAX + 1);
      end else if (m_pending) begin
         {e_fif, e_fid, e_fex, e_fmem} = 4'hF;
         e_ifs = 1;
         if (!bus.mem_busy_i) n_redir = 1;
      end else if (ev) begin
         {e_fif, e_fid, e_fex, e_fmem} = 4'hF;
         e_ifs = 1;
         n_pending = 1;
         n_redir   = !bus.mem_busy_i;
         n_mret    = !bus.wb_excp_i;
      end else if (bus.ex_br_taken_i) begin
         e_red = 1;
         e_pc  = bus.ex_br_target_i;
         e_fif = 1;
         e_fid = 1;
      end else if (lu) begin
         e_ifs = 1; e_ids = 1; e_bub = 1;
         if (m_stall < CNT_MAX) n_stall = m_stall + 1;
      end
      check_output("if_stall",    bus.if_stall_o,    e_ifs);
      check_output("id_stall",    bus.id_stall_o,    e_ids);
      check_output("ex_bubble",   bus.ex_bubble_o,   e_bub);
      check_output("flush_if",    bus.flush_if_o,    e_fif);
      check_output("flush_id",    bus.flush_id_o,    e_fid);
      check_output("flush_ex",    bus.flush_ex_o,    e_fex);
      check_output("flush_mem",   bus.flush_mem_o,   e_fmem);
      check_output("redirect",    bus.redirect_o,    e_red);
      check_output("redirect_pc", bus.redirect_pc_o, e_pc);
      check_output("trap_take",   bus.trap_take_o,   e_tt);
      check_output("mret_take",   bus.mret_take_o,   e_mt);
      check_output("state",       bus.state_o,       e_state);
      check_output("stall_cnt",   bus.stall_cnt_o,   m_stall);
      check_output("trap_cnt",    bus.trap_cnt_o,    m_trap);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_pending <= 0; m_redir <= 0; m_mret <= 0; m_stall <= 0; m_trap <= 0;
      end else begin
         m_pending <= n_pending; m_redir <= n_redir; m_mret <= n_mret;
         m_stall <= n_stall; m_trap <= n_trap;
      end
   end

   task automatic idle();
      bus.id_valid_i = 0; bus.id_rs1_ren_i = 0; bus.id_rs1_idx_i = 0;
      bus.id_rs2_ren_i = 0; bus.id_rs2_idx_i = 0;
      bus.ex_valid_i = 0; bus.ex_is_load_i = 0; bus.ex_rd_wen_i = 0; bus.ex_rd_idx_i = 0;
      bus.ex_br_taken_i = 0; bus.ex_br_target_i = 0;
      bus.wb_valid_i = 0; bus.wb_excp_i = 0; bus.wb_mret_i = 0; bus.mem_busy_i = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // EX: lw x<rd>; ID: add x6, x5, x7 reading rs1 (and rs2 = x7).
   task automatic apply_stimulus_load_use(input logic [4:0] rd);
      bus.ex_valid_i = 1; bus.ex_is_load_i = 1; bus.ex_rd_wen_i = 1; bus.ex_rd_idx_i = rd;
      bus.id_valid_i = 1; bus.id_rs1_ren_i = 1; bus.id_rs1_idx_i = rd;
      bus.id_rs2_ren_i = 1; bus.id_rs2_idx_i = 5'd7;
   endtask

   task automatic apply_stimulus_random();
      bus.id_valid_i     = ($urandom_range(0, 3) != 0);
      bus.id_rs1_ren_i   = 1'($urandom_range(0, 1));
      bus.id_rs1_idx_i   = 5'($urandom_range(0, 3));
      bus.id_rs2_ren_i   = 1'($urandom_range(0, 1));
      bus.id_rs2_idx_i   = 5'($urandom_range(0, 3));
      bus.ex_valid_i     = ($urandom_range(0, 3) != 0);
      bus.ex_is_load_i   = 1'($urandom_range(0, 1));
      bus.ex_rd_wen_i    = ($urandom_range(0, 3) != 0);
      bus.ex_rd_idx_i    = 5'($urandom_range(0, 3));
      bus.ex_br_taken_i  = ($urandom_range(0, 7) == 0);
      bus.ex_br_target_i = $urandom;
      bus.wb_valid_i     = ($urandom_range(0, 11) == 0);
      bus.wb_excp_i      = 1'($urandom_range(0, 1));
      bus.wb_mret_i      = 1'($urandom_range(0, 1));
      bus.mem_busy_i     = ($urandom_range(0, 2) == 0);
      bus.csr_mtvec_i    = $urandom;
      bus.csr_mepc_i     = $urandom;
   endtask

   initial begin : stimulus
      int drains, pulses;
      idle();
      bus.csr_mtvec_i = 32'h8000_0100;
      bus.csr_mepc_i  = 32'h8000_0024;
      repeat (2) @(negedge clk);
      check_output("reset_state",     bus.state_o,       0);
      check_output("reset_stall_cnt", bus.stall_cnt_o,   0);
      check_output("reset_trap_cnt",  bus.trap_cnt_o,    0);
      check_output("reset_redirect",  bus.redirect_o,    0);
      check_output("reset_pc",        bus.redirect_pc_o, 0);
      next_cycle();
      rst = 1;

      next_cycle();
      apply_stimulus_load_use(5'd5);
      @(negedge clk);
      check_output("lu_if_stall",  bus.if_stall_o,  1);
      check_output("lu_id_stall",  bus.id_stall_o,  1);
      check_output("lu_ex_bubble", bus.ex_bubble_o, 1);
      check_output("lu_cnt_before", bus.stall_cnt_o, 0);
      next_cycle();
      idle();
      @(negedge clk);
      check_output("lu_cnt_after", bus.stall_cnt_o, 1);
      check_output("lu_released",  bus.if_stall_o,  0);

      next_cycle();
      apply_stimulus_load_use(5'd0);
      @(negedge clk);
      check_output("x0_no_stall", bus.if_stall_o, 0);

      next_cycle();
      apply_stimulus_load_use(5'd5);
      bus.ex_br_taken_i = 1; bus.ex_br_target_i = 32'h8000_0040;
      @(negedge clk);
      check_output("br_redirect", bus.redirect_o,    1);
      check_output("br_pc",       bus.redirect_pc_o, 32'h8000_0040);
      check_output("br_flush_if", bus.flush_if_o,    1);
      check_output("br_flush_id", bus.flush_id_o,    1);
      check_output("br_no_stall", bus.if_stall_o,    0);
      next_cycle();
      idle();
      @(negedge clk);
      check_output("br_no_count", bus.stall_cnt_o, 1);

      next_cycle();
      bus.wb_valid_i = 1; bus.wb_excp_i = 1;
      @(negedge clk);
      check_output("trap_c0_flush_mem", bus.flush_mem_o, 1);
      check_output("trap_c0_if_stall",  bus.if_stall_o,  1);
      check_output("trap_c0_redirect",  bus.redirect_o,  0);
      next_cycle();
      idle();
      @(negedge clk);
      check_output("trap_c1_state",    bus.state_o,       2);
      check_output("trap_c1_redirect", bus.redirect_o,    1);
      check_output("trap_c1_pc",       bus.redirect_pc_o, 32'h8000_0100);
      check_output("trap_c1_take",     bus.trap_take_o,   1);
      next_cycle();
      @(negedge clk);
      check_output("trap_c2_state", bus.state_o,    0);
      check_output("trap_c2_cnt",   bus.trap_cnt_o, 1);

      next_cycle();
      bus.wb_valid_i = 1; bus.wb_excp_i = 1; bus.mem_busy_i = 1;
      drains = 0; pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.state_o == 2'd1) drains++;
         if (bus.redirect_o) pulses++;
         next_cycle();
         bus.wb_valid_i = 0; bus.wb_excp_i = 0;
         bus.mem_busy_i = (c < 2);
      end
      check_output("drain_cycles",    drains, 3);
      check_output("drain_redirects", pulses, 1);
      check_output("drain_trap_cnt",  bus.trap_cnt_o, 2);

      bus.wb_valid_i = 1; bus.wb_mret_i = 1;
      @(negedge clk);
      check_output("mret_c0_flush_ex", bus.flush_ex_o, 1);
      next_cycle();
      idle();
      @(negedge clk);
      check_output("mret_redirect",  bus.redirect_o,    1);
      check_output("mret_pc",        bus.redirect_pc_o, 32'h8000_0024);
      check_output("mret_take",      bus.mret_take_o,   1);
      check_output("mret_no_trap",   bus.trap_take_o,   0);
      next_cycle();
      @(negedge clk);
      check_output("mret_trap_cnt", bus.trap_cnt_o, 2);

      next_cycle();
      bus.wb_valid_i = 1; bus.wb_excp_i = 1; bus.mem_busy_i = 1;
      next_cycle();
      bus.wb_valid_i = 0; bus.wb_excp_i = 0;
      @(negedge clk);
      check_output("rstdrain_in_drain", bus.state_o, 1);
      next_cycle();
      rst = 0;
      @(negedge clk);
      check_output("rstdrain_state",     bus.state_o,     0);
      check_output("rstdrain_stall_cnt", bus.stall_cnt_o, 0);
      check_output("rstdrain_trap_cnt",  bus.trap_cnt_o,  0);
      next_cycle();
      rst = 1;
      bus.mem_busy_i = 0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.redirect_o || bus.trap_take_o || bus.mret_take_o) pulses++;
         next_cycle();
      end
      check_output("rstdrain_no_strobe", pulses, 0);

      apply_stimulus_load_use(5'd9);
      repeat (20) next_cycle();
      idle();
      @(negedge clk);
      check_output("stall_cnt_saturate", bus.stall_cnt_o, CNT_MAX);

      for (int i = 0; i < 2000; i++) begin
         next_cycle();
         apply_stimulus_random();
      end
      next_cycle();
      idle();
      repeat (4) next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
